// File: rtl/instruction_load_controller_pkg.sv
// Shared types and constants for the instruction load controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instruction_load_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int DEFAULT_ADDR_W = 16;

endpackage

// File: rtl/instruction_load_controller_if.sv
// Bundle of fetch, byte-loader and memory-port signals around the controller.
// Latency: n/a (wiring only).
// Backpressure: byte stream uses byte_valid/byte_ready; fetch uses fetch_stall.
interface instruction_load_controller_if
  import instruction_load_controller_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_stall;
  logic              fetch_valid;
  logic [31:0]       fetch_data;
  logic              load_start;
  logic [ADDR_W-1:0] load_count;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              load_busy;
  logic              load_done;
  logic              load_error;
  logic              mem_write_enable;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;

  // Controller side: owns the memory port, serves fetch and loader.
  modport slave (
    input  fetch_req, fetch_addr, load_start, load_count, byte_valid, byte_data, mem_read_data,
    output fetch_stall, fetch_valid, fetch_data, byte_ready, load_busy, load_done, load_error,
           mem_write_enable, mem_address, mem_write_data
  );

  // Environment side: fetch stage, host-link receiver and the memory itself.
  modport master (
    output fetch_req, fetch_addr, load_start, load_count, byte_valid, byte_data, mem_read_data,
    input  fetch_stall, fetch_valid, fetch_data, byte_ready, load_busy, load_done, load_error,
           mem_write_enable, mem_address, mem_write_data
  );
endinterface

// File: rtl/instruction_load_controller_word_assembler.sv
// Packs a byte stream big-endian into 32-bit words (first byte ends up in [31:24]).
// Latency: word register updated on the accepting edge; word_complete flags the 4th byte combinationally.
// Backpressure: none internally; caller only presents i_byte_vld when it can take the byte.
module instruction_load_controller_word_assembler
  import instruction_load_controller_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_byte_vld,
  input  logic [7:0]  i_byte_dat,
  output logic [31:0] o_word,
  output logic        o_word_complete
);

  logic [1:0]  r_count;
  logic [31:0] r_word;

  // Shift each accepted byte in at the bottom; the counter wraps to 0 after a full word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_word  <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_byte_vld) begin
      r_word  <= {r_word[23:0], i_byte_dat};
      r_count <= r_count + 2'd1;
    end
  end

  assign o_word          = r_word;
  assign o_word_complete = i_byte_vld && (r_count == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instruction_load_controller.sv
// Arbitrates the single instruction-memory port between CPU fetch and a byte-stream program loader.
// Latency: fetch data valid 1 cycle after acceptance; 5 cycles per loaded word (4 bytes + 1 write).
// Backpressure: fetch stalled while loading or on load_start; bytes accepted only while collecting.
module instruction_load_controller
  import instruction_load_controller_pkg::*;
#(
  parameter int          ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned MEM_SIZE = 20000
)
(
  input  logic i_clk,
  input  logic i_rst_n,
  instruction_load_controller_if.slave bus
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_waddr;
  logic [ADDR_W-1:0] r_load_count;
  logic              r_fetch_valid;
  logic              r_load_error;

  logic              w_run;
  logic              w_write;
  logic              w_start;
  logic              w_byte_ready;
  logic              w_byte_hs;
  logic              w_word_complete;
  logic              w_in_range;
  logic [31:0]       w_word;
  logic [ADDR_W-1:0] w_waddr_next;

  assign w_run        = (r_state == ST_RUN);
  assign w_write      = (r_state == ST_WRITE);
  assign w_start      = w_run && bus.load_start;
  assign w_byte_ready = (r_state == ST_COLLECT);
  assign w_byte_hs    = bus.byte_valid && w_byte_ready;
  assign w_in_range   = (32'(r_waddr) < MEM_SIZE);
  assign w_waddr_next = r_waddr + ADDR_W'(1);

  instruction_load_controller_word_assembler u_word_assembler (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_clear         (w_start),
    .i_byte_vld      (w_byte_hs),
    .i_byte_dat      (bus.byte_data),
    .o_word          (w_word),
    .o_word_complete (w_word_complete)
  );

  // Load sequencer, write address counter, sticky overflow flag and fetch-valid pipeline.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_RUN;
      r_waddr       <= '0;
      r_load_count  <= '0;
      r_load_error  <= 1'b0;
      r_fetch_valid <= 1'b0;
    end else begin
      r_fetch_valid <= w_run && bus.fetch_req && !bus.load_start;
      case (r_state)
        ST_RUN: begin
          if (bus.load_start) begin
            r_waddr      <= '0;
            r_load_count <= bus.load_count;
            r_load_error <= 1'b0;
            r_state      <= (bus.load_count != '0) ? ST_COLLECT : ST_DONE;
          end
        end
        ST_COLLECT: begin
          if (w_word_complete) r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          // Words past the end of memory are dropped but still counted toward load_count.
          if (!w_in_range) r_load_error <= 1'b1;
          r_waddr <= w_waddr_next;
          r_state <= (w_waddr_next == r_load_count) ? ST_DONE : ST_COLLECT;
        end
        ST_DONE: r_state <= ST_RUN;
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign bus.load_busy        = !w_run;
  assign bus.load_done        = (r_state == ST_DONE);
  assign bus.load_error       = r_load_error;
  assign bus.byte_ready       = w_byte_ready;
  assign bus.fetch_stall      = !w_run || bus.load_start;
  assign bus.fetch_valid      = r_fetch_valid;
  assign bus.fetch_data       = bus.mem_read_data;
  assign bus.mem_address      = w_write ? r_waddr : bus.fetch_addr;
  assign bus.mem_write_data   = w_word;
  assign bus.mem_write_enable = w_write && w_in_range;

endmodule

// File: tb/tb_instruction_load_controller.sv
// Self-checking bench: cycle-level model of the load/fetch timeline plus directed literal checks.
// Latency: n/a.
// Backpressure: byte source holds byte_valid while it has data and pops on handshake.
module tb_instruction_load_controller;

  localparam int MEM_SIZE = 4;

  logic clk;
  logic rst_n;

  instruction_load_controller_if #(.ADDR_W(16)) bus();

  instruction_load_controller #(.ADDR_W(16), .MEM_SIZE(MEM_SIZE)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int we_cnt   = 0;

  logic [31:0] env_mem   [0:63];
  logic [31:0] model_mem [0:63];
  logic [7:0]  bq[$];
  logic [7:0]  ld_bytes[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int n);
    bq = ld_bytes;
    bus.load_count = 16'(n);
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask

  // Synchronous-read instruction memory (read returns the old word on a same-cycle write).
  initial for (int i = 0; i < 64; i++) env_mem[i] = 32'hA000_0000 + 32'(i);
  always @(posedge clk) begin
    logic [31:0] rd;
    rd = env_mem[bus.mem_address[5:0]];
    if (bus.mem_write_enable) begin
      env_mem[bus.mem_address[5:0]] = bus.mem_write_data;
      we_cnt++;
    end
    bus.mem_read_data <= rd;
  end

  // Count completion pulses for the directed checks.
  always @(negedge clk) if (bus.load_done) done_cnt++;

  // Byte source: presents the head of bq, pops it after a handshake.
  initial begin
    bit take;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    forever begin
      @(negedge clk);
      take = bus.byte_valid && bus.byte_ready;
      @(posedge clk);
      #2;
      if (take && bq.size() > 0) void'(bq.pop_front());
      bus.byte_valid = (bq.size() > 0);
      bus.byte_data  = (bq.size() > 0) ? bq[0] : 8'h00;
    end
  end

  // Model: a load of n words started at cycle S is busy on S+1..S+5n+1 (S+1 for n==0),
  // writes word k at S+5k+5, pulses done on the last busy cycle; fetch answers a cycle later.
  initial begin
    int cyc, m_start, m_n, rel, dn_rel, k;
    bit in_load, m_err, m_fv, busy, wr, dn;
    logic [31:0] m_fd, wd;
    logic [7:0]  m_bytes[$];
    cyc = 0; m_start = 0; m_n = 0; in_load = 0; m_err = 0; m_fv = 0; m_fd = '0;
    for (int i = 0; i < 64; i++) model_mem[i] = 32'hA000_0000 + 32'(i);
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        in_load = 0; m_err = 0; m_fv = 0;
      end
      busy = 0; wr = 0; dn = 0; k = 0; wd = '0;
      if (in_load) begin
        rel    = cyc - m_start;
        dn_rel = (m_n == 0) ? 1 : 5 * m_n + 1;
        busy   = (rel >= 1) && (rel <= dn_rel);
        dn     = (rel == dn_rel);
        wr     = (m_n != 0) && (rel % 5 == 0) && (rel <= 5 * m_n);
        k      = rel / 5 - 1;
        if (wr) wd = {m_bytes[4*k], m_bytes[4*k+1], m_bytes[4*k+2], m_bytes[4*k+3]};
      end
      chk("fetch_stall", 32'(bus.fetch_stall), 32'(busy || bus.load_start));
      chk("fetch_valid", 32'(bus.fetch_valid), 32'(m_fv));
      if (m_fv) chk("fetch_data", bus.fetch_data, m_fd);
      chk("load_busy", 32'(bus.load_busy), 32'(busy));
      chk("load_done", 32'(bus.load_done), 32'(dn));
      chk("byte_ready", 32'(bus.byte_ready), 32'(busy && !wr && !dn));
      chk("load_error", 32'(bus.load_error), 32'(m_err));
      chk("mem_we", 32'(bus.mem_write_enable), 32'(wr && k < MEM_SIZE));
      if (wr) begin
        chk("mem_addr_wr", 32'(bus.mem_address), 32'(k));
        chk("mem_wdata", bus.mem_write_data, wd);
      end else if (!busy) begin
        chk("mem_addr_run", 32'(bus.mem_address), 32'(bus.fetch_addr));
      end
      if (wr) begin
        if (k < MEM_SIZE) model_mem[k] = wd;
        else m_err = 1;
      end
      if (dn) in_load = 0;
      m_fv = rst_n && !busy && bus.fetch_req && !bus.load_start;
      if (m_fv) m_fd = model_mem[bus.fetch_addr[5:0]];
      if (rst_n && !busy && bus.load_start) begin
        in_load = 1; m_start = cyc; m_n = int'(bus.load_count);
        m_bytes = ld_bytes; m_err = 0;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.load_start = 1'b0;
    bus.load_count = '0;
    // Reset state
    tick(); tick();
    @(negedge clk);
    chk("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    chk("rst_mem_wdata", bus.mem_write_data, 32'd0);
    chk("rst_load_busy", 32'(bus.load_busy), 32'd0);
    tick();
    rst_n = 1'b1;

    // Back-to-back fetches 0,1,2
    bus.fetch_req = 1'b1; bus.fetch_addr = 16'd0; tick();
    bus.fetch_addr = 16'd1; tick();
    bus.fetch_addr = 16'd2; tick();
    bus.fetch_req = 1'b0;
    @(negedge clk);
    chk("fetch2_valid", 32'(bus.fetch_valid), 32'd1);
    chk("fetch2_data", bus.fetch_data, 32'hA000_0002);
    tick();

    // Two-word load
    done_cnt = 0;
    ld_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    start_load(2);
    repeat (12) tick();
    chk("load2_mem0", env_mem[0], 32'hDEAD_BEEF);
    chk("load2_mem1", env_mem[1], 32'h0123_4567);
    chk("load2_done_cnt", 32'(done_cnt), 32'd1);
    bus.fetch_req = 1'b1; bus.fetch_addr = 16'd1; tick();
    bus.fetch_req = 1'b0;
    @(negedge clk);
    chk("fetch_after_load", bus.fetch_data, 32'h0123_4567);
    tick();

    // Zero-length load
    done_cnt = 0; we_cnt = 0;
    ld_bytes = {};
    start_load(0);
    repeat (3) tick();
    chk("load0_done_cnt", 32'(done_cnt), 32'd1);
    chk("load0_no_write", 32'(we_cnt), 32'd0);

    // Fetch coincident with load_start, held during the load
    ld_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    bus.fetch_req = 1'b1; bus.fetch_addr = 16'd3;
    start_load(1);
    repeat (8) tick();
    bus.fetch_req = 1'b0;
    tick();
    chk("load1_mem0", env_mem[0], 32'h1122_3344);

    // Reset after two bytes collected, then a fresh load
    ld_bytes = '{8'h55, 8'h66, 8'h77, 8'h88};
    start_load(1);
    tick(); tick();
    rst_n = 1'b0;
    bq.delete();
    @(negedge clk);
    chk("midrst_load_busy", 32'(bus.load_busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    ld_bytes = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    start_load(1);
    repeat (7) tick();
    chk("after_rst_mem0", env_mem[0], 32'hCAFE_F00D);

    // Overflow: six words into a four-word memory
    done_cnt = 0;
    ld_bytes = {};
    for (int i = 0; i < 24; i++) ld_bytes.push_back(8'(8'h10 + i));
    start_load(6);
    repeat (32) tick();
    chk("ovf_error", 32'(bus.load_error), 32'd1);
    chk("ovf_mem3", env_mem[3], 32'h1C1D_1E1F);
    chk("ovf_mem4_untouched", env_mem[4], 32'hA000_0004);
    chk("ovf_mem5_untouched", env_mem[5], 32'hA000_0005);
    chk("ovf_done_cnt", 32'(done_cnt), 32'd1);
    ld_bytes = {};
    start_load(0);
    repeat (2) tick();
    chk("ovf_error_cleared", 32'(bus.load_error), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_load_controller.md
# instruction_load_controller

Sequencer that owns the single port of the instruction memory and shares it between the CPU fetch stage and a byte-stream program loader (e.g. UART receiver). In run mode it forwards fetch addresses and flags the synchronous read data one cycle later. In load mode it stalls fetch, packs incoming bytes big-endian into 32-bit words and writes them to consecutive addresses from 0. It sits between the core's fetch logic, the host-link receiver and the instruction memory.

## Interface
- ADDR_W, 16: memory address width
- MEM_SIZE, 20000: words in instruction memory; writes at or above this are suppressed
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_req  in  1  fetch read request for fetch_addr
- fetch_addr  in  ADDR_W  fetch word address
- fetch_stall  out  1  request not accepted this cycle
- fetch_valid  out  1  fetch_data valid (one cycle after accepted request)
- fetch_data  out  32  fetched instruction (passthrough of mem_read_data)
- load_start  in  1  pulse: enter load mode, word address := 0
- load_count  in  ADDR_W  words to load, sampled on load_start
- byte_valid  in  1  byte_data valid
- byte_data  in  8  program byte, most-significant byte of each word first
- byte_ready  out  1  byte accepted when byte_valid & byte_ready
- load_busy  out  1  load mode active
- load_done  out  1  one-cycle pulse at end of load
- load_error  out  1  sticky: load_count exceeded MEM_SIZE; cleared by next load_start
- mem_write_enable  out  1  to memory write_enable
- mem_address  out  ADDR_W  to memory address
- mem_write_data  out  32  to memory write_data
- mem_read_data  in  32  from memory read_data (registered, 1-cycle latency)

## Operation
- States: RUN, COLLECT, WRITE, DONE. Reset state RUN.
- RUN: mem_address = fetch_addr, mem_write_enable = 0; fetch accepted when fetch_req & ~load_start.
- RUN -> COLLECT on load_start with load_count != 0; RUN -> DONE on load_start with load_count == 0. Word address, byte count := 0; load_error := 0.
- COLLECT: byte_ready = 1; each handshake shifts byte into word register (word := {word[23:0], byte}), byte count++. On 4th byte -> WRITE.
- WRITE: byte_ready = 0; mem_address = word address, mem_write_data = word, mem_write_enable = 1 if word address < MEM_SIZE, else 0 and load_error := 1. Then word address++; if new address == load_count -> DONE else COLLECT, byte count := 0.
- DONE: load_done = 1 for exactly this cycle, then RUN.
- load_busy = 1 in COLLECT, WRITE, DONE; fetch_stall = load_busy | load_start.
- load_start outside RUN is ignored; byte_valid in RUN or DONE is ignored (byte_ready = 0).
- Word address and load_count compare at ADDR_W bits; load_count = 2^ADDR_W-1 maximum, no wrap.
- Reset at any point: state RUN, all counters and word register 0, partial word discarded.

## Timing
- Reset values: fetch_stall 0, fetch_valid 0, byte_ready 0, load_busy 0, load_done 0, load_error 0, mem_write_enable 0, mem_address = fetch_addr (combinational), mem_write_data 0.
- Fetch latency 1: accepted at cycle N -> fetch_valid = 1 and fetch_data valid at N+1. fetch_valid is a register of the accepted flag; never 1 in the cycle after a WRITE.
- Back-to-back fetches every cycle at full throughput in RUN.
- Load throughput: 4 byte cycles + 1 write cycle per word; minimum 5 cycles per word.
- load_start seen at cycle N: load_busy = 1 from N+1; fetch_stall = 1 already at N.
- Last write at cycle M -> load_done at M+1 -> fetch accepted from M+2.

## Structure
- Shared package: state enum (RUN, COLLECT, WRITE, DONE), BYTES_PER_WORD = 4, default ADDR_W.
- Sub-module word_assembler: byte shift register and 2-bit byte counter, outputs word and word_complete; controller FSM, address counter and fetch mux in top.

## Test plan
- Reset mid-COLLECT after 2 bytes -> state RUN, load_busy 0, next load writes fresh word at address 0.
- RUN: fetch_req addresses 0,1,2 on consecutive cycles with preloaded memory -> fetch_valid on cycles 1-3 with matching data, fetch_stall 0.
- load_start, load_count = 2, bytes DE AD BE EF 01 23 45 67 -> writes 0xDEADBEEF at 0, 0x01234567 at 1, load_done pulse once, then fetch of 1 returns 0x01234567.
- load_count = 0 -> load_done the cycle after load_start, no mem write, load_busy high one cycle.
- fetch_req coincident with load_start -> fetch_stall 1, no fetch_valid next cycle; fetch_req during load stays stalled.
- MEM_SIZE = 4, load_count = 6 -> writes at 0-3 only, load_error 1 after 5th word, load_done still pulses; next load_start clears load_error.
